// File: rtl/nv_clk_gate_en_ctrl_if.sv
// -----------------------------------------------------------------------------
// nv_clk_gate_en_ctrl_if
// Signal bundle between the clock-gate enable controller and the logic that
// feeds it activity / wake requests and consumes the enable and status.
//
// Signals:
//   act_in        [NUM_SRC] per-source busy/pending level
//   wake_req                 level request for a running clock, held until wake_ack
//   cfg_idle_hyst [HYST_W]   idle hysteresis count
//   cfg_override             1 forces the clock on
//   clk_en                   registered enable to the gate cell
//   wake_ack                 1 when the gated clock is guaranteed running
//   gated_status             1 while gated
//   gate_cnt      [CNT_W]    saturating count of gating events
//
// Modports:
//   master - requester side (drives activity/config, reads enable/status)
//   slave  - controller side
// -----------------------------------------------------------------------------
interface nv_clk_gate_en_ctrl_if #(
  parameter int NUM_SRC = 4,
  parameter int HYST_W  = 8,
  parameter int CNT_W   = 16
);
  logic [NUM_SRC-1:0] act_in;
  logic               wake_req;
  logic [HYST_W-1:0]  cfg_idle_hyst;
  logic               cfg_override;
  logic               clk_en;
  logic               wake_ack;
  logic               gated_status;
  logic [CNT_W-1:0]   gate_cnt;

  modport master (
    output act_in, wake_req, cfg_idle_hyst, cfg_override,
    input  clk_en, wake_ack, gated_status, gate_cnt
  );

  modport slave (
    input  act_in, wake_req, cfg_idle_hyst, cfg_override,
    output clk_en, wake_ack, gated_status, gate_cnt
  );
endinterface

// File: rtl/nv_clk_gate_en_ctrl.sv
// -----------------------------------------------------------------------------
// nv_clk_gate_en_ctrl
// Idle-detect controller producing the clk_en input of a clock-gate cell.
// Runs on the ungated clock. After cfg_idle_hyst+1 consecutive idle cycles in
// IDLE_WAIT the enable is dropped; any activity in GATED re-enables the clock
// and wake_ack follows only after WAKE_LAT cycles of settle time.
//
// Ports:
//   clk    - ungated clock
//   reset  - synchronous, active-high reset
//   bus    - nv_clk_gate_en_ctrl_if.slave (activity, wake, config, status)
//
// Build option:
//   NV_CLK_GATE_CTRL_STATS_EN - when defined, gate_cnt counts RUN->GATED
//   entries (saturating); when undefined the counter is absent and gate_cnt
//   reads 0.
// -----------------------------------------------------------------------------
module nv_clk_gate_en_ctrl #(
  parameter int NUM_SRC  = 4,
  parameter int HYST_W   = 8,
  parameter int WAKE_LAT = 2,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  nv_clk_gate_en_ctrl_if.slave  bus
);

  localparam int WAKE_W = (WAKE_LAT > 1) ? $clog2(WAKE_LAT) : 1;
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_LAT - 1);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    IDLE_WAIT = 2'd1,
    GATED     = 2'd2,
    WAKE      = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [HYST_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic [WAKE_W-1:0]  wake_cnt_q, wake_cnt_d;
  logic               clk_en_q, wake_ack_q, gated_status_q;
  logic               gate_evt;
  logic [NUM_SRC-1:0] act_src;
  logic               activity;

  assign act_src  = bus.act_in;
  assign activity = (|act_src) | bus.wake_req | bus.cfg_override;

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;
    gate_evt   = 1'b0;
    case (state_q)
      RUN: begin
        if (!activity) begin
          state_d    = IDLE_WAIT;
          idle_cnt_d = '0;
        end
      end
      IDLE_WAIT: begin
        // Activity has priority over hysteresis expiry. The >= compare makes a
        // hysteresis value lowered below the running count gate immediately.
        if (activity) begin
          state_d    = RUN;
          idle_cnt_d = '0;
        end else if (idle_cnt_q >= bus.cfg_idle_hyst) begin
          state_d  = GATED;
          gate_evt = 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      GATED: begin
        if (activity) begin
          state_d    = WAKE;
          wake_cnt_d = '0;
        end
      end
      WAKE: begin
        // Settle period always runs to completion regardless of activity.
        if (wake_cnt_q == WAKE_LAST) begin
          state_d = RUN;
        end else begin
          wake_cnt_d = wake_cnt_q + 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RUN;
      idle_cnt_q     <= '0;
      wake_cnt_q     <= '0;
      clk_en_q       <= 1'b1;
      wake_ack_q     <= 1'b1;
      gated_status_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      idle_cnt_q     <= idle_cnt_d;
      wake_cnt_q     <= wake_cnt_d;
      clk_en_q       <= (state_d != GATED);
      wake_ack_q     <= (state_d == RUN) || (state_d == IDLE_WAIT);
      gated_status_q <= (state_d == GATED);
    end
  end

  assign bus.clk_en       = clk_en_q;
  assign bus.wake_ack     = wake_ack_q;
  assign bus.gated_status = gated_status_q;

`ifdef NV_CLK_GATE_CTRL_STATS_EN
  logic [CNT_W-1:0] gate_cnt_q, gate_cnt_d;

  // Saturate at all-ones rather than wrap.
  always_comb begin
    gate_cnt_d = gate_cnt_q;
    if (gate_evt && (gate_cnt_q != {CNT_W{1'b1}})) begin
      gate_cnt_d = gate_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gate_cnt_q <= '0;
    end else begin
      gate_cnt_q <= gate_cnt_d;
    end
  end

  assign bus.gate_cnt = gate_cnt_q;
`else
  logic unused_gate_evt;
  assign unused_gate_evt = gate_evt;
  assign bus.gate_cnt    = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/nv_clk_gate_en_ctrl.md
Name: nv_clk_gate_en_ctrl

Overview:
- Idle-detect controller that generates the clk_en input of a power clock-gate cell.
- Runs on the ungated clock and watches per-source activity and a wake request.
- Drops clk_en after a programmable idle hysteresis.
- On wake, re-enables the clock and acknowledges only after a fixed settle latency, so the requester never uses a clock that is still gated.

Parameters:
- NUM_SRC, 4, number of activity source bits.
- HYST_W, 8, width of the idle hysteresis config field.
- WAKE_LAT, 2, cycles clk_en must be high before wake_ack asserts; legal minimum is 1.
- CNT_W, 16, width of the gating-event counter.

Ports:
- clk  in  1  ungated clock.
- reset  in  1  synchronous, active-high reset.
- act_in  in  NUM_SRC  per-source busy/pending indication, level.
- wake_req  in  1  level request for a running clock; held until wake_ack=1.
- cfg_idle_hyst  in  HYST_W  idle hysteresis count.
- cfg_override  in  1  1 forces the clock on (debug / disable gating).
- clk_en  out  1  registered enable to the gate cell.
- wake_ack  out  1  registered; 1 when the gated clock is guaranteed running.
- gated_status  out  1  registered; 1 while in GATED.
- gate_cnt  out  CNT_W  saturating count of RUN-to-GATED entries.

Behaviour:
- Interface: one clock, clk. Reset port reset is synchronous and active-high.
- Reset values: state=RUN, clk_en=1, wake_ack=1, gated_status=0, idle_cnt=0, wake_cnt=0, gate_cnt=0.
- Definition: activity = |act_in | wake_req | cfg_override.
- FSM RUN: clk_en=1.
  - !activity -> IDLE_WAIT with idle_cnt=0.
  - Otherwise stay in RUN.
- FSM IDLE_WAIT: clk_en=1.
  - activity -> RUN, idle_cnt=0.
  - else if idle_cnt >= cfg_idle_hyst -> GATED, clk_en<=0, gate_cnt++.
  - else idle_cnt++.
- FSM GATED: clk_en=0, gated_status=1.
  - activity -> WAKE, clk_en<=1, wake_cnt=0.
- FSM WAKE: clk_en=1.
  - wake_cnt increments each cycle.
  - When wake_cnt==WAKE_LAT-1 -> RUN.
  - Activity changes are ignored in WAKE; WAKE always completes.
- Gating latency: first idle cycle sampled in RUN at cycle T gives clk_en=0 visible from cycle T+cfg_idle_hyst+2.
- Wake latency: activity sampled in GATED at cycle T gives clk_en=1 from T+1 and wake_ack=1 from T+WAKE_LAT+1.
- wake_ack is registered and equals (next_state==RUN || next_state==IDLE_WAIT). It is 0 in GATED and WAKE.
- gated_status is registered and equals (next_state==GATED).
- cfg_idle_hyst may change at any time. Because the compare is >=, a value lowered below idle_cnt gates on the next cycle.
- cfg_idle_hyst=0: gate one cycle after entering IDLE_WAIT.
- gate_cnt saturates at all-ones with no wrap. It is cleared only by reset.
- Simultaneous activity and hysteresis expiry in IDLE_WAIT: activity wins, go to RUN, no gate.
- Reset asserted in any state: the next cycle shows the reset values, so clk_en=1 immediately after reset.
- No X permitted on clk_en after reset. The bench asserts this.

Optional Feature:
- Macro NV_CLK_GATE_CTRL_STATS_EN.
- Defined: gate_cnt is implemented as specified.
- Undefined: the gate_cnt register is removed and the output is tied to 0; all other behaviour is identical.

Test Plan:
- Reset, then act_in=0, wake_req=0, cfg_idle_hyst=3 -> clk_en=1 for 5 cycles, then 0 from cycle 5; gated_status=1; gate_cnt=1.
- GATED, pulse act_in[2] for 1 cycle, WAKE_LAT=2 -> clk_en=1 next cycle; wake_ack=1 two cycles later; state RUN, or IDLE_WAIT on the following cycle.
- IDLE_WAIT with idle_cnt=2 and cfg_idle_hyst=3, act_in[0]=1 on the expiry cycle -> no gating, clk_en stays 1, gate_cnt unchanged.
- cfg_override=1 for 100 idle cycles -> clk_en stays 1, wake_ack=1. Drop override with cfg_idle_hyst=0 -> clk_en=0 two cycles later.
- Force gate_cnt to all-ones minus 1 via 65534 gate/wake loops, then 3 more loops -> gate_cnt=16'hFFFF, no wrap. Without the macro, gate_cnt=0 throughout.
- Assert reset during WAKE with wake_cnt=0 -> next cycle clk_en=1, wake_ack=1, gated_status=0, gate_cnt=0.
